// File: rtl/encoder_ssi_rx_multi.sv
// Multi-lane SSI/SPI absolute-encoder receiver: per-lane start detect, MSB-first
// frame capture, optional parity, enforced inter-frame gap and an all-lanes strobe.
module encoder_ssi_rx_multi #(
    parameter int NUM_CH     = 2,
    parameter int FRAME_W    = 24,
    parameter int DATA_MSB   = 21,
    parameter int DATA_LSB   = 3,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int GAP_MIN    = 4,
    localparam int DATA_W    = DATA_MSB - DATA_LSB + 1
) (
    input  logic                       sck,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [NUM_CH-1:0]          miso,
    output logic [NUM_CH*FRAME_W-1:0]  frame_full,
    output logic [NUM_CH*DATA_W-1:0]   encoder_val,
    output logic [NUM_CH-1:0]          data_valid,
    output logic [NUM_CH-1:0]          parity_err,
    output logic                       all_valid
);

    localparam int CW = $clog2(FRAME_W);
    localparam int GW = (GAP_MIN > 1) ? $clog2(GAP_MIN) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    state_t              state [NUM_CH];
    logic [FRAME_W-2:0]  shreg [NUM_CH];
    logic [CW-1:0]       cnt   [NUM_CH];
    logic [GW-1:0]       gcnt  [NUM_CH];
    logic [FRAME_W-1:0]  nxt   [NUM_CH];
    logic [NUM_CH-1:0]   seen;

    // Frame as it stands once the current miso bit is shifted in.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            nxt[i] = {shreg[i], miso[i]};
        end
    end

    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            frame_full  <= '0;
            encoder_val <= '0;
            data_valid  <= '0;
            parity_err  <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                state[i] <= IDLE;
                shreg[i] <= '0;
                cnt[i]   <= '0;
                gcnt[i]  <= '0;
            end
        end else begin
            data_valid <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                case (state[i])
                    IDLE: begin
                        if (en && !miso[i]) begin
                            state[i] <= SHIFT;
                            cnt[i]   <= '0;
                        end
                    end
                    SHIFT: begin
                        shreg[i] <= nxt[i][FRAME_W-2:0];
                        cnt[i]   <= cnt[i] + 1'b1;
                        if (cnt[i] == CW'(FRAME_W - 1)) begin
                            frame_full[i*FRAME_W +: FRAME_W] <= nxt[i];
                            encoder_val[i*DATA_W +: DATA_W]  <= nxt[i][DATA_MSB:DATA_LSB];
                            parity_err[i] <= (PARITY_EN != 0) &&
                                             ((^nxt[i]) != (PARITY_ODD != 0));
                            data_valid[i] <= 1'b1;
                            state[i]      <= GAP;
                            gcnt[i]       <= '0;
                        end
                    end
                    GAP: begin
                        if (!miso[i]) begin
                            gcnt[i] <= '0;
                        end else if (gcnt[i] == GW'(GAP_MIN - 1)) begin
                            state[i] <= IDLE;
                        end else begin
                            gcnt[i] <= gcnt[i] + 1'b1;
                        end
                    end
                    default: state[i] <= IDLE;
                endcase
            end
        end
    end

    // Valids landing in the completing cycle are absorbed by that strobe.
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            seen      <= '0;
            all_valid <= 1'b0;
        end else if (&(seen | data_valid)) begin
            seen      <= '0;
            all_valid <= 1'b1;
        end else begin
            seen      <= seen | data_valid;
            all_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_encoder_ssi_rx_multi.sv
// Bench for encoder_ssi_rx_multi: directed scenarios plus random lane traffic,
// compared every cycle against a bit-stream model of the receiver.
module tb_encoder_ssi_rx_multi;

    localparam int NC   = 2;
    localparam int FW   = 24;
    localparam int DW   = 19;
    localparam int DLSB = 3;
    localparam int GMIN = 4;

    logic                 sck = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 en = 1'b0;
    logic [NC-1:0]        miso = '1;
    logic [NC*FW-1:0]     frame_full;
    logic [NC*DW-1:0]     encoder_val;
    logic [NC-1:0]        data_valid;
    logic [NC-1:0]        parity_err;
    logic                 all_valid;
    logic [FW-1:0]        frame_full1;
    logic [DW-1:0]        encoder_val1;
    logic                 data_valid1;
    logic                 parity_err1;
    logic                 all_valid1;

    encoder_ssi_rx_multi u_dut (
        .sck(sck), .rst_n(rst_n), .en(en), .miso(miso),
        .frame_full(frame_full), .encoder_val(encoder_val),
        .data_valid(data_valid), .parity_err(parity_err), .all_valid(all_valid)
    );

    encoder_ssi_rx_multi #(.NUM_CH(1), .PARITY_EN(0)) u_dut1 (
        .sck(sck), .rst_n(rst_n), .en(en), .miso(miso[0]),
        .frame_full(frame_full1), .encoder_val(encoder_val1),
        .data_valid(data_valid1), .parity_err(parity_err1), .all_valid(all_valid1)
    );

    always #5 sck = ~sck;

    int checks = 0;
    int errors = 0;

    // Stimulus queues and global drive controls
    bit q0[$];
    bit q1[$];
    bit en_r  = 1'b1;
    bit rst_r = 1'b0;

    // Reference model: expected outputs after the most recent edge
    int            left    [NC];
    logic [FW-1:0] acc     [NC];
    bit            in_gap  [NC];
    int            run     [NC];
    logic [FW-1:0] m_frame [NC];
    bit [NC-1:0]   m_perr;
    bit [NC-1:0]   m_dv;
    bit [NC-1:0]   m_seen;
    bit            m_all;
    bit            m_all1;

    // Observation bookkeeping for the directed scenarios
    int tick_no = 0;
    int dv_cnt0 = 0;
    int av_cnt  = 0;
    int both_cnt = 0;
    int t_dv0 = -1;
    int t_dv1 = -1;
    int t_av  = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            left[i] = 0; acc[i] = '0; in_gap[i] = 1'b0; run[i] = 0; m_frame[i] = '0;
        end
        m_perr = '0; m_dv = '0; m_seen = '0; m_all = 1'b0; m_all1 = 1'b0;
    endtask

    task automatic model_step(input bit en_v, input bit [NC-1:0] b);
        bit nxt_all;
        nxt_all = ((m_seen | m_dv) == '1);
        m_all1  = m_dv[0];
        m_seen  = nxt_all ? '0 : (m_seen | m_dv);
        m_all   = nxt_all;
        m_dv    = '0;
        for (int i = 0; i < NC; i++) begin
            if (left[i] > 0) begin
                acc[i] = {acc[i][FW-2:0], b[i]};
                left[i]--;
                if (left[i] == 0) begin
                    m_frame[i] = acc[i];
                    m_perr[i]  = ($countones(acc[i]) % 2) != 0;
                    m_dv[i]    = 1'b1;
                    in_gap[i]  = 1'b1;
                    run[i]     = 0;
                end
            end else if (in_gap[i]) begin
                if (b[i]) begin
                    run[i]++;
                    if (run[i] == GMIN) in_gap[i] = 1'b0;
                end else begin
                    run[i] = 0;
                end
            end else if (en_v && !b[i]) begin
                left[i] = FW;
            end
        end
    endtask

    task automatic check_outputs();
        logic [NC*FW-1:0] ef;
        logic [NC*DW-1:0] ev;
        logic [FW-1:0]    sh;
        for (int i = 0; i < NC; i++) begin
            ef[i*FW +: FW] = m_frame[i];
            sh = m_frame[i] >> DLSB;
            ev[i*DW +: DW] = sh[DW-1:0];
        end
        chk("frame_full",  64'(frame_full),  64'(ef));
        chk("encoder_val", 64'(encoder_val), 64'(ev));
        chk("data_valid",  64'(data_valid),  64'(m_dv));
        chk("parity_err",  64'(parity_err),  64'(m_perr));
        chk("all_valid",   64'(all_valid),   64'(m_all));
        chk("frame_full1",  64'(frame_full1),  64'(ef[FW-1:0]));
        chk("encoder_val1", 64'(encoder_val1), 64'(ev[DW-1:0]));
        chk("data_valid1",  64'(data_valid1),  64'(m_dv[0]));
        chk("parity_err1",  64'(parity_err1),  64'd0);
        chk("all_valid1",   64'(all_valid1),   64'(m_all1));
    endtask

    task automatic tick();
        bit [NC-1:0] b;
        @(negedge sck);
        tick_no++;
        check_outputs();
        if (data_valid[0]) begin dv_cnt0++; t_dv0 = tick_no; end
        if (data_valid[1]) t_dv1 = tick_no;
        if (data_valid == 2'b11) both_cnt++;
        if (all_valid) begin av_cnt++; t_av = tick_no; end
        b[0] = (q0.size() > 0) ? q0.pop_front() : 1'b1;
        b[1] = (q1.size() > 0) ? q1.pop_front() : 1'b1;
        miso  = b;
        en    = en_r;
        rst_n = rst_r;
        if (rst_r) model_step(en_r, b);
        else       model_reset();
    endtask

    task automatic push_bit(input int lane, input bit v);
        if (lane == 0) q0.push_back(v);
        else           q1.push_back(v);
    endtask

    task automatic push_frame(input int lane, input logic [FW-1:0] v, input int pre, input bit trail);
        for (int k = 0; k < pre; k++) push_bit(lane, 1'b1);
        push_bit(lane, 1'b0);
        for (int k = FW - 1; k >= 0; k--) push_bit(lane, v[k]);
        if (trail) for (int k = 0; k < GMIN; k++) push_bit(lane, 1'b1);
    endtask

    task automatic drain();
        while (q0.size() > 0 || q1.size() > 0) tick();
        repeat (3) tick();
    endtask

    task automatic clear_obs();
        dv_cnt0 = 0; av_cnt = 0; both_cnt = 0; t_dv0 = -1; t_dv1 = -1; t_av = -1;
    endtask

    initial begin
        int t;
        bit seen_dv;
        model_reset();
        repeat (3) tick();
        rst_r = 1'b1;
        repeat (2) tick();

        // First frame on lane 0: latency and literal decode
        clear_obs();
        push_frame(0, 24'h123457, 0, 1'b1);
        t = 0; seen_dv = 1'b0;
        while (!seen_dv && t < 60) begin
            tick(); t++;
            seen_dv = (dv_cnt0 > 0);
        end
        chk("latency_ticks", 64'(t), 64'(FW + 2));
        chk("lit_frame",  64'(frame_full[FW-1:0]),  64'h123457);
        chk("lit_enc",    64'(encoder_val[DW-1:0]), 64'h2468A);
        chk("lit_perr",   64'(parity_err[0]),       64'd0);
        drain();

        // Odd number of ones: parity error on the default instance only
        push_frame(0, 24'h123456, 0, 1'b1);
        drain();
        chk("lit_frame_b", 64'(frame_full[FW-1:0]),  64'h123456);
        chk("lit_enc_b",   64'(encoder_val[DW-1:0]), 64'h2468A);
        chk("lit_perr_b",  64'(parity_err[0]),       64'd1);
        chk("lit_perr_nopar", 64'(parity_err1),      64'd0);

        // Lows inside the gap must not start a frame
        clear_obs();
        push_frame(0, 24'h123457, 0, 1'b0);
        push_bit(0, 1'b0);
        repeat (3) push_bit(0, 1'b1);
        push_bit(0, 1'b0);
        repeat (GMIN) push_bit(0, 1'b1);
        push_frame(0, 24'h0F0F0F, 0, 1'b1);
        drain();
        chk("gap_dv_count", 64'(dv_cnt0), 64'd2);
        chk("gap_frame",    64'(frame_full[FW-1:0]), 64'h0F0F0F);

        // Lane 0 finishes 5 cycles ahead of lane 1
        clear_obs();
        push_frame(0, 24'hABCDEF, 0, 1'b1);
        push_frame(1, 24'h135791, 5, 1'b1);
        drain();
        chk("skew_dv_gap", 64'(t_dv1 - t_dv0), 64'd5);
        chk("skew_av_lat", 64'(t_av - t_dv1),  64'd1);
        chk("skew_av_cnt", 64'(av_cnt),        64'd1);
        chk("skew_frame1", 64'(frame_full[FW +: FW]), 64'h135791);

        // Both lanes finish on the same edge
        clear_obs();
        push_frame(0, 24'h00FF00, 0, 1'b1);
        push_frame(1, 24'hFF00FF, 0, 1'b1);
        drain();
        chk("sync_both_cnt", 64'(both_cnt), 64'd1);
        chk("sync_av_cnt",   64'(av_cnt),   64'd1);

        // Reset after 10 frame bits aborts the frame
        clear_obs();
        push_frame(0, 24'hFEDCBA, 0, 1'b1);
        repeat (11) tick();
        rst_r = 1'b0;
        q0.delete(); q1.delete();
        repeat (2) tick();
        chk("rst_frame", 64'(frame_full), 64'd0);
        chk("rst_dv",    64'(dv_cnt0),    64'd0);
        rst_r = 1'b1;
        tick();
        push_frame(0, 24'h654321, 0, 1'b1);
        drain();
        chk("post_rst_frame", 64'(frame_full[FW-1:0]), 64'h654321);

        // Start bit ignored while disabled
        clear_obs();
        en_r = 1'b0;
        push_frame(0, 24'h000000, 0, 1'b1);
        drain();
        chk("en_off_dv", 64'(dv_cnt0), 64'd0);
        en_r = 1'b1;
        repeat (GMIN + 2) tick();

        // Disable after bit 5 of a frame already running
        clear_obs();
        push_frame(0, 24'h5A5A5A, 0, 1'b1);
        repeat (6) tick();
        en_r = 1'b0;
        drain();
        en_r = 1'b1;
        chk("en_drop_dv",    64'(dv_cnt0), 64'd1);
        chk("en_drop_frame", 64'(frame_full[FW-1:0]), 64'h5A5A5A);

        // Random traffic with occasional enable drops and one reset
        for (int c = 0; c < 3000; c++) begin
            for (int ln = 0; ln < NC; ln++) begin
                if ((ln == 0 ? q0.size() : q1.size()) == 0) begin
                    if ($urandom_range(0, 1) == 0)
                        push_frame(ln, FW'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
                    else
                        for (int k = 0; k < int'($urandom_range(1, 6)); k++)
                            push_bit(ln, 1'($urandom_range(0, 1)));
                end
            end
            en_r  = ($urandom_range(0, 9) != 0);
            rst_r = (c != 1500);
            tick();
        end
        rst_r = 1'b1;
        en_r  = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/encoder_ssi_rx_multi.md
Name: encoder_ssi_rx_multi

Overview:
Multi-channel, parametrised successor to the single-channel SSI/SPI absolute-encoder reader. It receives NUM_CH independent encoder serial lanes that share one clock. Each lane detects a start bit and shifts in a FRAME_W-bit frame, MSB first. For each frame the block extracts the position field, checks optional parity, enforces a minimum inter-frame gap, and publishes per-channel results plus an "all channels updated" strobe for the motion-control logic.

Parameters:
NUM_CH, 2, number of encoder lanes (1..8)
FRAME_W, 24, bits per frame after the start bit (8..32)
DATA_MSB, 21, MSB index of the position field within the frame
DATA_LSB, 3, LSB index of the position field; DATA_W = DATA_MSB-DATA_LSB+1 (19 by default)
PARITY_EN, 1, 1: frame bit 0 is a parity bit over the whole frame
PARITY_ODD, 0, 0: even parity (XOR of all FRAME_W bits = 0); 1: odd parity (XOR = 1)
GAP_MIN, 4, consecutive miso-high cycles required after a frame before a new start bit is accepted

Ports:
sck  in  1  free-running clock; all sampling happens on the rising edge
rst_n  in  1  asynchronous, active-low reset
en  in  1  global enable; gates only the IDLE->SHIFT transition
miso  in  NUM_CH  serial data, lane i on bit i, idle high
frame_full  out  NUM_CH*FRAME_W  last complete raw frame, lane i at [i*FRAME_W +: FRAME_W]
encoder_val  out  NUM_CH*DATA_W  position field of the last frame, lane i at [i*DATA_W +: DATA_W]
data_valid  out  NUM_CH  one-cycle pulse per lane when its outputs update
parity_err  out  NUM_CH  parity result of the last frame; valid with and after data_valid
all_valid  out  1  one-cycle pulse once every lane has posted at least one frame since the previous pulse

Behaviour:
- Reset: all outputs 0; every lane FSM in IDLE; counters, shift registers and the seen mask are cleared. A reset mid-frame aborts the frame with no partial publish.
- Each lane has an independent FSM with states IDLE, SHIFT and GAP.
- IDLE: on an edge with en=1 and miso[i]=0, the start bit is consumed and the lane goes to SHIFT with cnt=0. With en=0 the lane stays in IDLE.
- SHIFT: each edge does shreg <= {shreg[FRAME_W-2:0], miso[i]} and cnt <= cnt+1. Exactly FRAME_W bits are sampled, with no extra bit.
- Publish: on the edge that samples the last bit (cnt==FRAME_W-1), the block registers frame_full, encoder_val and parity_err from the combined value {shreg[FRAME_W-2:0], miso[i]}. On that same edge it sets data_valid[i]=1 and moves to GAP with gcnt=0.
- Latency: data_valid is high in the cycle immediately after the last bit is sampled, which is FRAME_W+1 edges after the start-bit edge.
- data_valid is high for exactly one cycle per frame. frame_full, encoder_val and parity_err hold their values until the next publish.
- Parity:
  - PARITY_EN=1: parity_err = (^frame) != PARITY_ODD.
  - PARITY_EN=0: parity_err is always 0.
  - The frame is published even when parity fails.
- GAP: if miso[i]=1, gcnt increments; if miso[i]=0, gcnt is reset to 0 and no start is accepted. When gcnt reaches GAP_MIN-1 with miso high, the lane returns to IDLE. A low in the cycle right after a frame therefore cannot start a new frame.
- en=0 mid-frame does not affect the frame in progress or the GAP phase.
- all_valid:
  - A seen mask accumulates data_valid.
  - When (seen | data_valid) is all ones, the block pulses all_valid one cycle later and clears seen.
  - Valids that arrive in the completing cycle are consumed by that pulse.
  - With NUM_CH=1, all_valid follows data_valid delayed by one cycle.
- Lanes never interact, except through all_valid. Simultaneous publishes on several lanes are all honoured in the same cycle.

Test Plan:
- Single lane, default parameters: start bit, then frame 24'h123457 MSB-first. Required: data_valid[0] pulses on the edge after the 24th bit; frame_full=24'h123457; encoder_val=19'h2468A; parity_err=0 (10 ones, even).
- Same lane, frame 24'h123456 (9 ones). Required: data_valid[0] pulses; encoder_val=19'h2468A; parity_err[0]=1. Then set PARITY_EN=0 and repeat. Required: parity_err=0.
- Gap: drive miso low 1 cycle after the frame, then high for 3 cycles, then low. Required: no new frame starts. After 4 consecutive high cycles, a low starts a frame that completes normally.
- Two lanes, lane 0 frame ends 5 cycles before lane 1 frame. Required: data_valid=2'b01, then 2'b10, then all_valid pulses once, 1 cycle after lane 1's valid. Then repeat with both lanes ending on the same edge. Required: data_valid=2'b11 and exactly one all_valid.
- Reset and enable: assert rst_n=0 after 10 bits of a frame. Required: all outputs read 0, no data_valid, and the next frame decodes correctly. With en=0, drive a start bit. Required: no capture. Drop en at bit 5 of an in-progress frame. Required: that frame still publishes.
